// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: single-outstanding load/store controller with range checking,
// sign/zero extension for sub-word loads and read-modify-write for sub-word stores.
module mem_access_ctrl #(
    parameter int                AWIDTH    = 32,
    parameter int                DWIDTH    = 32,
    parameter logic [AWIDTH-1:0] BASE_ADDR = 32'h01000000,
    parameter int                DEPTH     = 1048576
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [AWIDTH-1:0] req_addr_i,
    input  logic [DWIDTH-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DWIDTH-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [AWIDTH-1:0] mem_addr_o,
    output logic [DWIDTH-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [DWIDTH-1:0] mem_data_i
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;

    localparam logic [AWIDTH:0] LIMIT = {1'b0, BASE_ADDR} + (AWIDTH+1)'(DEPTH - 1);

    state_t            r_state, w_next;
    logic              r_write, r_unsigned, r_err;
    logic [1:0]        r_size;
    logic [AWIDTH-1:0] r_addr;
    logic [DWIDTH-1:0] r_wdata, r_rdata;
    logic              w_accept, w_err;
    logic [AWIDTH:0]   w_last;
    logic [DWIDTH-1:0] w_merge, w_load;

    assign w_accept   = req_valid_i && req_ready_o;
    // Last byte address is computed one bit wider so a request wrapping past the top is rejected.
    assign w_last     = {1'b0, req_addr_i} + (AWIDTH+1)'(req_size_i == 2'b00 ? 0 : req_size_i == 2'b01 ? 1 : 3);
    assign w_err      = (req_size_i == 2'b11) || (req_addr_i < BASE_ADDR) || (w_last > LIMIT);
    assign mem_addr_o = r_addr;

    assign w_merge = (r_size == 2'b00) ? {r_rdata[DWIDTH-1:8], r_wdata[7:0]}
                                       : {r_rdata[DWIDTH-1:16], r_wdata[15:0]};
    assign w_load  = (r_size == 2'b00) ? {{(DWIDTH-8){~r_unsigned & r_rdata[7]}}, r_rdata[7:0]}
                   : (r_size == 2'b01) ? {{(DWIDTH-16){~r_unsigned & r_rdata[15]}}, r_rdata[15:0]}
                   : r_rdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        req_ready_o    = 1'b0;
        resp_valid_o   = 1'b0;
        resp_err_o     = 1'b0;
        resp_rdata_o   = '0;
        mem_read_en_o  = 1'b0;
        mem_write_en_o = 1'b0;
        mem_data_o     = '0;
        case (r_state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i)
                    w_next = w_err ? RESP : !req_write_i ? RD : (req_size_i == 2'b10) ? WR : RMW_RD;
            end
            RD: begin
                mem_read_en_o = 1'b1;
                w_next        = RESP;
            end
            RMW_RD: begin
                mem_read_en_o = 1'b1;
                w_next        = WR;
            end
            WR: begin
                mem_write_en_o = !rst;
                mem_data_o     = (r_size == 2'b10) ? r_wdata : w_merge;
                w_next         = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                resp_err_o   = r_err;
                resp_rdata_o = (r_err || r_write) ? '0 : w_load;
                w_next       = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_write    <= 1'b0;
            r_unsigned <= 1'b0;
            r_err      <= 1'b0;
            r_size     <= 2'b00;
            r_addr     <= BASE_ADDR;
            r_wdata    <= '0;
            r_rdata    <= '0;
        end else begin
            if (w_accept) begin
                r_write    <= req_write_i;
                r_unsigned <= req_unsigned_i;
                r_err      <= w_err;
                r_size     <= req_size_i;
                r_addr     <= req_addr_i;
                r_wdata    <= req_wdata_i;
            end
            if (mem_read_en_o) r_rdata <= mem_data_i;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a small byte-array memory
// covering BASE..BASE+63; addresses outside that window read as zero and ignore writes.
module tb_mem_access_ctrl;
    localparam logic [31:0] BASE = 32'h01000000;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_write_i, req_unsigned_i;
    logic [1:0]  req_size_i;
    logic [31:0] req_addr_i, req_wdata_i;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o, mem_addr_o, mem_data_o, mem_data_i;
    logic        mem_read_en_o, mem_write_en_o;

    logic [7:0]  mem [0:63];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          en_bad = 0;
    logic        err_win = 1'b0;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_write_i(req_write_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_addr_i(req_addr_i),
        .req_wdata_i(req_wdata_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
        .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_data_i(mem_data_i)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        mem_data_i = '0;
        if (mem_read_en_o)
            for (int k = 0; k < 4; k++)
                if (mem_addr_o - BASE + k < 64) mem_data_i[8*k +: 8] = mem[6'(mem_addr_o - BASE + k)];
    end

    always @(posedge clk)
        if (mem_write_en_o)
            for (int k = 0; k < 4; k++)
                if (mem_addr_o - BASE + k < 64) mem[6'(mem_addr_o - BASE + k)] <= mem_data_o[8*k +: 8];

    function automatic logic [31:0] mword(input logic [31:0] a);
        return {mem[6'(a - BASE + 3)], mem[6'(a - BASE + 2)], mem[6'(a - BASE + 1)], mem[6'(a - BASE)]};
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    // Monitor: pops one expectation per response pulse and checks data, error flag and timing.
    always @(negedge clk) begin
        if (mem_read_en_o && mem_write_en_o) begin
            checks++;
            errors++;
            $display("FAIL both_enables: read_en and write_en high at cycle %0d", cyc);
        end
        if (err_win && (mem_read_en_o || mem_write_en_o)) en_bad++;
        if (resp_valid_o) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got response at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_err"}, 32'(resp_err_o), 32'(e.err));
                chk({e.name, "_rdata"}, resp_rdata_o, e.rdata);
                chk({e.name, "_cycle"}, cyc, e.cyc);
                chk({e.name, "_ready_in_resp"}, 32'(req_ready_o), 32'd0);
            end
        end
    end

    task automatic issue(input string nm, input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic ee, input logic [31:0] er, input int lat);
        int g;
        @(negedge clk);
        req_write_i = w; req_size_i = sz; req_unsigned_i = u;
        req_addr_i = a; req_wdata_i = d; req_valid_i = 1'b1;
        g = 0;
        while (!req_ready_o && g < 20) begin @(negedge clk); g++; end
        if (g >= 20) begin
            checks++; errors++;
            $display("FAIL %s_accept: got no ready expected ready within 20 cycles", nm);
        end
        @(posedge clk);
        #1;
        q.push_back('{ee, er, cyc + lat - 1, nm});
        req_valid_i = 1'b0;
        g = 0;
        while (q.size() != 0 && g < 20) begin @(negedge clk); g++; end
        if (q.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got no response expected one within 20 cycles", nm);
            q.delete();
        end
    endtask

    initial begin
        int acc;
        logic rdy;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        rst = 1'b1; req_valid_i = 1'b0; req_write_i = 1'b0; req_size_i = 2'b00;
        req_unsigned_i = 1'b0; req_addr_i = '0; req_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(req_ready_o), 1);
        chk("rst_resp_valid", 32'(resp_valid_o), 0);
        chk("rst_resp_err", 32'(resp_err_o), 0);
        chk("rst_rdata", resp_rdata_o, 0);
        chk("rst_read_en", 32'(mem_read_en_o), 0);
        chk("rst_write_en", 32'(mem_write_en_o), 0);
        chk("rst_mem_data", mem_data_o, 0);
        chk("rst_mem_addr", mem_addr_o, BASE);

        issue("st_word", 1, 2'b10, 0, 32'h01000004, 32'hDEADBEEF, 0, 0, 2);
        issue("ld_word", 0, 2'b10, 0, 32'h01000004, 0, 0, 32'hDEADBEEF, 2);
        issue("st_byte", 1, 2'b00, 0, 32'h01000005, 32'h11223380, 0, 0, 3);
        chk("mem_after_byte", mword(32'h01000004), 32'hDEAD80EF);
        issue("ld_byte_s", 0, 2'b00, 0, 32'h01000005, 0, 0, 32'hFFFFFF80, 2);
        issue("ld_byte_u", 0, 2'b00, 1, 32'h01000005, 0, 0, 32'h00000080, 2);
        issue("st_half", 1, 2'b01, 0, 32'h01000006, 32'hFFFF1234, 0, 0, 3);
        chk("mem_after_half", mword(32'h01000004), 32'h123480EF);
        issue("ld_after_half", 0, 2'b10, 0, 32'h01000004, 0, 0, 32'h123480EF, 2);
        issue("ld_half_s", 0, 2'b01, 0, 32'h01000004, 0, 0, 32'hFFFF80EF, 2);
        issue("ld_half_u", 0, 2'b01, 1, 32'h01000004, 0, 0, 32'h000080EF, 2);
        issue("st_aabb", 1, 2'b10, 0, 32'h01000000, 32'hAABBCCDD, 0, 0, 2);
        issue("st_zero", 1, 2'b10, 0, 32'h01000004, 32'h00000000, 0, 0, 2);
        issue("ld_unaligned", 0, 2'b10, 0, 32'h01000001, 0, 0, 32'h00AABBCC, 2);

        err_win = 1'b1;
        issue("err_below", 0, 2'b10, 0, 32'h00FFFFFF, 0, 1, 0, 1);
        issue("err_size", 0, 2'b11, 0, 32'h01000000, 0, 1, 0, 1);
        issue("err_top", 1, 2'b10, 0, 32'h010FFFFE, 32'h55555555, 1, 0, 1);
        issue("err_wrap", 0, 2'b10, 0, 32'hFFFFFFFF, 0, 1, 0, 1);
        err_win = 1'b0;
        chk("err_enables", en_bad, 0);
        chk("mem_after_err", mword(32'h01000000), 32'hAABBCCDD);

        issue("ld_last_byte", 0, 2'b00, 0, 32'h010FFFFF, 0, 0, 0, 2);
        issue("ld_last_word", 0, 2'b10, 0, 32'h010FFFFC, 0, 0, 0, 2);

        issue("st_1234", 1, 2'b10, 0, 32'h0100000C, 32'h12345678, 0, 0, 2);
        @(negedge clk);
        req_write_i = 1'b1; req_size_i = 2'b10; req_addr_i = 32'h0100000C;
        req_wdata_i = 32'hFFFFFFFF; req_valid_i = 1'b1;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
        chk("wr_we_before_rst", 32'(mem_write_en_o), 1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_wr_ready", 32'(req_ready_o), 1);
        chk("rst_wr_resp", 32'(resp_valid_o), 0);
        chk("rst_wr_addr", mem_addr_o, BASE);
        chk("rst_wr_mem", mword(32'h0100000C), 32'h12345678);
        issue("ld_after_rst", 0, 2'b10, 0, 32'h0100000C, 0, 0, 32'h12345678, 2);

        @(negedge clk);
        req_write_i = 1'b0; req_size_i = 2'b10; req_unsigned_i = 1'b0;
        req_addr_i = 32'h01000000; req_valid_i = 1'b1;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            rdy = req_ready_o;
            if (k == 0 || k == 3) chk("b2b_ready_idle", 32'(rdy), 1);
            else chk("b2b_ready_busy", 32'(rdy), 0);
            @(posedge clk);
            #1;
            if (rdy) begin
                acc++;
                q.push_back('{1'b0, 32'hAABBCCDD, cyc + 1, "b2b_load"});
            end
        end
        req_valid_i = 1'b0;
        chk("b2b_accepts", acc, 2);
        repeat (3) @(negedge clk);
        chk("b2b_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish expected finish within 100000 time units");
        $fatal(1);
    end
endmodule
